// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_if
// Purpose  : Request/result bundle between the execute stage and div_unit.
// Revision : 1.0  initial release
// ============================================================================
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    // Execute-stage side
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // Divider side
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle restoring radix-2 divider; result = {remainder, quotient}.
// Revision : 1.0  initial release
// ============================================================================
module div_unit #(
    parameter int DATA_W = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    div_unit_if.slave   bus
);

    localparam int                  c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [DATA_W-1:0]      r_dividend;
    logic [DATA_W-1:0]      w_dividend_nxt;
    logic [DATA_W-1:0]      r_divisor;
    logic [DATA_W-1:0]      w_divisor_nxt;
    logic [DATA_W-1:0]      r_partial;
    logic [DATA_W-1:0]      w_partial_nxt;
    logic [DATA_W-1:0]      r_quot;
    logic [DATA_W-1:0]      w_quot_nxt;
    logic                   r_signed;
    logic                   w_signed_nxt;
    logic                   r_sign1;
    logic                   w_sign1_nxt;
    logic                   r_sign2;
    logic                   w_sign2_nxt;
    logic [2*DATA_W-1:0]    r_result;
    logic [2*DATA_W-1:0]    w_result_nxt;
    logic                   r_ready;
    logic                   w_ready_nxt;

    logic [DATA_W-1:0]      w_abs1;
    logic [DATA_W-1:0]      w_abs2;
    logic [DATA_W:0]        w_shifted;
    logic                   w_fits;
    logic [DATA_W-1:0]      w_diff;
    logic [DATA_W-1:0]      w_quot_fix;
    logic [DATA_W-1:0]      w_rem_fix;

    // Magnitudes of the incoming operands for signed requests
    assign w_abs1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? (-bus.opdata1_i)
                                                                  : bus.opdata1_i;
    assign w_abs2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? (-bus.opdata2_i)
                                                                  : bus.opdata2_i;

    // The restored partial remainder is always below the divisor, so it fits
    // in DATA_W bits; only the shifted trial value needs the extra bit.
    assign w_shifted = {r_partial, r_dividend[DATA_W-1]};
    assign w_fits    = (w_shifted >= {1'b0, r_divisor});
    // When the trial fits, the true difference is below the divisor, so the
    // low DATA_W bits of the subtraction are exact.
    assign w_diff    = w_shifted[DATA_W-1:0] - r_divisor;

    // Quotient takes the XOR of operand signs, remainder the dividend's sign
    assign w_quot_fix = (r_signed && (r_sign1 ^ r_sign2)) ? (-r_quot) : r_quot;
    assign w_rem_fix  = (r_signed && r_sign1) ? (-r_partial) : r_partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FREE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_partial  <= '0;
            r_quot     <= '0;
            r_signed   <= 1'b0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_partial  <= w_partial_nxt;
            r_quot     <= w_quot_nxt;
            r_signed   <= w_signed_nxt;
            r_sign1    <= w_sign1_nxt;
            r_sign2    <= w_sign2_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_partial_nxt  = r_partial;
        w_quot_nxt     = r_quot;
        w_signed_nxt   = r_signed;
        w_sign1_nxt    = r_sign1;
        w_sign2_nxt    = r_sign2;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;

        case (r_state)
            S_FREE: begin
                w_ready_nxt  = 1'b0;
                w_result_nxt = '0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        w_state_nxt = S_BYZERO;
                    end else begin
                        w_state_nxt    = S_ON;
                        w_cnt_nxt      = '0;
                        w_dividend_nxt = w_abs1;
                        w_divisor_nxt  = w_abs2;
                        w_partial_nxt  = '0;
                        w_quot_nxt     = '0;
                        w_signed_nxt   = bus.signed_div_i;
                        w_sign1_nxt    = bus.opdata1_i[DATA_W-1];
                        w_sign2_nxt    = bus.opdata2_i[DATA_W-1];
                    end
                end
            end

            S_BYZERO: begin
                w_state_nxt  = S_END;
                w_result_nxt = '0;
                w_ready_nxt  = 1'b1;
            end

            S_ON: begin
                if (bus.annul_i) begin
                    w_state_nxt  = S_FREE;
                    w_cnt_nxt    = '0;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt  = S_END;
                    w_result_nxt = {w_rem_fix, w_quot_fix};
                    w_ready_nxt  = 1'b1;
                end else begin
                    w_partial_nxt  = w_fits ? w_diff : w_shifted[DATA_W-1:0];
                    w_quot_nxt     = {r_quot[DATA_W-2:0], w_fits};
                    w_dividend_nxt = {r_dividend[DATA_W-2:0], 1'b0};
                    w_cnt_nxt      = r_cnt + c_CNT_ONE;
                end
            end

            S_END: begin
                if (!bus.start_i) begin
                    w_state_nxt  = S_FREE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = '0;
                end else begin
                    w_ready_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt  = S_FREE;
                w_ready_nxt  = 1'b0;
                w_result_nxt = '0;
            end
        endcase
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Directed and randomized self-checking bench for div_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    div_unit_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with C-style truncation toward zero
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        int     ia, ib;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            ia = a;
            ib = b;
            sa = ia;
            sb = ib;
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp_res, input int exp_lat,
                           input int hold_extra, input int chg_at, input logic [31:0] chg_val);
        int lat;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        bus.start_i      = 1'b1;
        @(negedge clk);
        lat = 0;
        while (bus.ready_o !== 1'b1 && lat < 40) begin
            if (lat == chg_at) begin
                bus.opdata1_i    = chg_val;
                bus.opdata2_i    = ~b;
                bus.signed_div_i = ~sgn;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, bus.result_o, exp_res);
        for (int k = 0; k < hold_extra; k++) begin
            @(negedge clk);
            check({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
            check({tag, " hold result"}, bus.result_o, exp_res);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        check({tag, " drop ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, " drop result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          seen;

        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        repeat (3) @(negedge clk);
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle ready", 64'(bus.ready_o), 64'd0);

        run_div("udiv 100/7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 0, -1, 32'd0);
        run_div("sdiv -7/2", 32'hFFFFFFF9, 32'h2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0, -1, 32'd0);
        run_div("sdiv 7/-2", 32'h7, 32'hFFFFFFFE, 1'b1, {32'h1, 32'hFFFFFFFD}, 33, 0, -1, 32'd0);
        run_div("div by zero", 32'h12345678, 32'h0, 1'b0, 64'd0, 1, 1, -1, 32'd0);

        // Annul sampled at E10 together with EX dropping its request
        bus.opdata1_i    = 32'hFFFFFFFF;
        bus.opdata2_i    = 32'd3;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        check("annul ready", 64'(bus.ready_o), 64'd0);
        check("annul result", bus.result_o, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) seen++;
        end
        check("annul quiet", 64'(seen), 64'd0);
        run_div("sdiv overflow", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 0, -1, 32'd0);

        // Synchronous reset sampled at E15 of an operation in progress
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        @(negedge clk);
        repeat (14) @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("midreset ready", 64'(bus.ready_o), 64'd0);
        check("midreset result", bus.result_o, 64'd0);
        rst = 1'b0;
        run_div("udiv max/1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, 0, -1, 32'd0);

        run_div("operand change", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 5, 2, 32'd5);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_div("random", ra, rb, rs, ref_div(ra, rb, rs), (rb == 32'd0) ? 1 : 33,
                    int'($urandom_range(0, 2)), 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
